shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: N, default 7, MSB index of each operand; operands are N+1 bits wide (0 to Nth bit).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiplication; sampled only when ready=1.
REQ-005 a  input  N+1  multiplicand, unsigned; sampled on the edge that accepts start.
REQ-006 b  input  N+1  multiplier, unsigned; sampled on the edge that accepts start.
REQ-007 ready  output  1  high only in IDLE; block accepts start.
REQ-008 busy  output  1  high only in RUN.
REQ-009 done  output  1  one-cycle pulse; product updated in the same cycle.
REQ-010 product  output  2N+2  registered unsigned result a*b, held until the next done.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 IDLE: start=1 at an edge -> latch a into mcand, b into mplier, clear acc (2N+2 bits) and count, go to RUN; start=0 -> stay.
REQ-013 RUN: each edge performs one iteration; after N+1 iterations (count = N) go to DONE.
REQ-014 Iteration: if mplier LSB=1, form an (N+2)-bit sum = acc[2N+1:N+1] + mcand, carry-in 0, ripple-carry style; else sum = {1'b0, acc[2N+1:N+1]}.
REQ-015 Iteration (cont.): acc <= {sum, acc[N:1]} (one-bit logical right shift of {sum, acc[N:0]}); mplier <= mplier >> 1; count <= count + 1.
REQ-016 The carry out of the adder SHALL never be discarded; the full (N+2)-bit sum feeds the shift, so no overflow is possible.
REQ-017 On the edge leaving RUN, product <= final acc, and done SHALL be high for the whole following cycle (DONE state).
REQ-018 DONE: unconditionally return to IDLE on the next edge; done returns low.
REQ-019 Latency: with start accepted at edge E, done SHALL be high in the cycle after edge E+N+1 (cycle E+N+2 for N=7: 9 cycles after the start cycle).
REQ-020 start while busy=1 or during DONE SHALL be ignored, with no effect on state, operands or product.
REQ-021 a and b changes after acceptance SHALL not affect the in-flight result.
REQ-022 product SHALL change only on the edge that enters DONE (or on reset).
REQ-023 Back-to-back: start held high SHALL be accepted again in the IDLE cycle following DONE; minimum issue interval N+3 cycles.
REQ-024 ready, busy and done SHALL be decoded from state only (no combinational path from start).
REQ-025 Operand value 0 on either input SHALL still take the full N+1 iterations (no early exit).

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, ready=1, busy=0, done=0, product=0, acc/mcand/mplier/count=0, independent of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse is produced for it, and product reads 0.
REQ-028 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 N=7, a=13, b=11, start one cycle -> done pulse 9 cycles later (after edge E+8), product=143 (0x008F).
REQ-030 N=7, a=255, b=255 -> product=65025 (0xFE01), confirming the carry out of the top adder bit is retained.
REQ-031 N=7, a=0, b=200 then a=200, b=0 -> product=0 each time, full latency, one done pulse each.
REQ-032 N=7, a=6, b=7 accepted, then start=1 with a=9, b=9 during RUN -> second start ignored, product=42, exactly one done.
REQ-033 N=7, a=100, b=3 accepted, reset pulsed at iteration 4 -> done never asserts, product=0, ready=1. Then a=100, b=3 -> product=300 (0x012C).
REQ-034 N=7, start held high continuously with a=2, b=3 then a=4, b=5 -> done pulses 10 cycles apart, products 6 then 20.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one shift-and-add iteration per clock,
// N+1 iterations per product, three-state IDLE/RUN/DONE control.
module shift_add_multiplier #(
   parameter int N = 7
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N:0]     a,
   input  logic [N:0]     b,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [2*N+1:0] product
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_next;
   logic [N:0]      mcand;
   logic [N:0]      mplier;
   logic [2*N+1:0]  acc;
   logic [2*N+1:0]  acc_next;
   logic [CW-1:0]   count;
   logic [N:0]      addend;
   logic [N+1:0]    sum;
   logic            carry;
   logic            last_iter;

   assign last_iter = (count == CW'(N));

   // Ripple-carry add of the upper accumulator half; the carry out becomes sum[N+1].
   always_comb begin
      // NOTE: blocking assignments here model combinational ripple; registers below use <=.
      addend = mplier[0] ? mcand : '0;
      carry  = 1'b0;
      sum    = '0;
      for (int i = 0; i <= N; i++) begin
         sum[i] = acc[N+1+i] ^ addend[i] ^ carry;
         carry  = (acc[N+1+i] & addend[i]) | (carry & (acc[N+1+i] ^ addend[i]));
      end
      sum[N+1] = carry;
      acc_next = {sum, acc[N:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Status outputs decode the state only, so start never reaches them combinationally.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_next = state;
      ready      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_iter) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= '0;
                  count  <= '0;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (last_iter) product <= acc_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: a transaction-level model (latched operands, phase count,
// plain a*b) is compared against every DUT output on every falling edge.
module tb_shift_add_multiplier;

   localparam int N  = 7;
   localparam int PW = 2 * N + 2;

   logic          clk;
   logic          reset;
   logic          start;
   logic [N:0]    a_i;
   logic [N:0]    b_i;
   logic          ready;
   logic          busy;
   logic          done;
   logic [PW-1:0] product;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;

   int      done_cyc[$];
   longint  done_prod[$];

   // Reference model state: phase 0 idle, 1..N+1 computing, N+2 result pulse.
   int            m_phase = 0;
   logic [N:0]    m_a, m_b;
   logic [PW-1:0] m_prod = '0;

   shift_add_multiplier #(.N(N)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a_i),
      .b       (b_i),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase = 0;
         m_prod  = '0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_a     = a_i;
            m_b     = b_i;
            m_phase = 1;
         end
      end else if (m_phase == N + 1) begin
         m_prod  = PW'(m_a) * PW'(m_b);
         m_phase = N + 2;
      end else if (m_phase == N + 2) begin
         m_phase = 0;
      end else begin
         m_phase++;
      end
   end

   always @(negedge clk) begin
      cyc++;
      check("ready",   ready,   m_phase == 0);
      check("busy",    busy,    (m_phase >= 1) && (m_phase <= N + 1));
      check("done",    done,    m_phase == N + 2);
      check("product", product, m_prod);
      if (done) begin
         done_cyc.push_back(cyc);
         done_prod.push_back(longint'(product));
      end
   end

   // Stimulus moves just after the falling edge, clear of both sampling points.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!ready && k < 30) begin
         tick();
         k++;
      end
      if (!ready) check("ready_timeout", 0, 1);
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (done_cyc.size() < target && k < 40) begin
         tick();
         k++;
      end
      check("done_timeout", done_cyc.size() >= target, 1);
   endtask

   task automatic run_op(input logic [N:0] x, input logic [N:0] y, input longint exp);
      int base, c0;
      wait_ready();
      start = 1'b1;
      a_i   = x;
      b_i   = y;
      base  = done_cyc.size();
      c0    = cyc;
      tick();
      start = 1'b0;
      a_i   = N'($urandom);
      b_i   = N'($urandom);
      wait_done(base + 1);
      if (done_cyc.size() > base) begin
         check("latency", done_cyc[base] - c0, N + 2);
         check("result",  done_prod[base], exp);
      end
   endtask

   initial begin
      int base;
      reset = 1'b1;
      start = 1'b0;
      a_i   = '0;
      b_i   = '0;
      tick();
      tick();
      check("rst_ready",   ready,   1);
      check("rst_busy",    busy,    0);
      check("rst_done",    done,    0);
      check("rst_product", product, 0);
      reset = 1'b0;

      run_op(8'd13,  8'd11,  143);
      run_op(8'd255, 8'd255, 65025);
      run_op(8'd0,   8'd200, 0);
      run_op(8'd200, 8'd0,   0);

      // Start requests during RUN must be ignored.
      wait_ready();
      base  = done_cyc.size();
      start = 1'b1;
      a_i   = 8'd6;
      b_i   = 8'd7;
      tick();
      a_i   = 8'd9;
      b_i   = 8'd9;
      repeat (5) tick();
      start = 1'b0;
      wait_done(base + 1);
      if (done_cyc.size() > base) check("ignore_start_prod", done_prod[base], 42);
      repeat (12) tick();
      check("ignore_start_one_done", done_cyc.size() - base, 1);

      // Reset in the middle of RUN aborts without a done pulse.
      wait_ready();
      base  = done_cyc.size();
      start = 1'b1;
      a_i   = 8'd100;
      b_i   = 8'd3;
      tick();
      start = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_ready",   ready,   1);
      check("abort_product", product, 0);
      repeat (15) tick();
      check("abort_no_done", done_cyc.size() - base, 0);
      run_op(8'd100, 8'd3, 300);

      // Start held high: back-to-back issue every N+3 cycles.
      wait_ready();
      base  = done_cyc.size();
      start = 1'b1;
      a_i   = 8'd2;
      b_i   = 8'd3;
      tick();
      a_i   = 8'd4;
      b_i   = 8'd5;
      wait_done(base + 1);
      tick();
      tick();
      start = 1'b0;
      wait_done(base + 2);
      if (done_cyc.size() > base + 1) begin
         check("b2b_first",    done_prod[base],     6);
         check("b2b_second",   done_prod[base + 1], 20);
         check("b2b_interval", done_cyc[base + 1] - done_cyc[base], N + 3);
      end

      repeat (12) begin
         logic [N:0] x, y;
         x = N'($urandom);
         y = N'($urandom);
         run_op(x, y, longint'(x) * longint'(y));
      end

      // Free-running random traffic, including occasional resets; model-checked only.
      repeat (400) begin
         tick();
         start = ($urandom_range(0, 2) == 0);
         a_i   = N'($urandom);
         b_i   = N'($urandom);
         reset = ($urandom_range(0, 149) == 0);
      end
      reset = 1'b0;
      start = 1'b0;
      repeat (20) tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
